// File: rtl/sub_share_pkg.sv
// Shared types and helpers for the shared-subtractor arbiter.
//   state_t   : arbiter FSM states
//   rr_pick_t : round-robin search result {found, index}
//   rr_pick() : round-robin search over a zero-padded request vector
package sub_share_pkg;

    localparam int N_DEF    = 3;
    localparam int NREQ_DEF = 4;

    // The round-robin search works on a fixed-width vector so that one
    // function serves any NREQ up to RR_MAX.
    localparam int RR_MAX   = 32;
    localparam int RR_IDX_W = $clog2(RR_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] index;
    } rr_pick_t;

    // First set bit of valid, searching ptr, ptr+1, ... (mod RR_MAX).
    // Bits above NREQ are zero, so wrapping mod RR_MAX visits the real
    // requesters in the same order as wrapping mod NREQ would.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0]   valid,
                                         input logic [RR_IDX_W-1:0] ptr);
        rr_pick_t            res;
        logic [RR_IDX_W-1:0] idx;
        res = '0;
        // Walk from the farthest candidate to the nearest so the nearest wins.
        for (int k = RR_MAX - 1; k >= 0; k--) begin
            idx = ptr + RR_IDX_W'(k);
            if (valid[idx]) begin
                res.found = 1'b1;
                res.index = idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sub_share_arbiter_if.sv
// Request/response bus of the shared-subtractor arbiter.
//   req_valid/req_ready : per-requester handshake, NREQ bits
//   req_a/req_b         : packed operands, requester i at [i*N +: N]
//   resp_*              : common tagged response channel
//   busy                : arbiter not idle
// slave = arbiter side, master = requester/consumer side.
interface sub_share_arbiter_if
    import sub_share_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int NREQ = NREQ_DEF
);
    localparam int ID_W = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic              resp_valid;
    logic              resp_ready;
    logic [ID_W-1:0]   resp_id;
    logic [N-1:0]      resp_diff;
    logic              resp_borrow;
    logic              resp_zero;
    logic              busy;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_diff, resp_borrow,
               resp_zero, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_id, resp_diff, resp_borrow,
               resp_zero, busy
    );

endinterface

// File: rtl/subtractor.sv
// Plain N-bit adder used as a subtractor: {cout, sum} = a + ~b + cin.
//   a, b : operands      cin  : carry in (1 for a - b)
//   sum  : N-bit result  cout : carry out (0 means borrow)
module subtractor #(
    parameter int N = 3
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N-1:0] b_inv;

    assign b_inv       = ~b;
    assign {cout, sum} = (N+1)'(a) + (N+1)'(b_inv) + (N+1)'(cin);

endmodule

// File: rtl/sub_share_arbiter.sv
// Shares one subtractor among NREQ requesters with round-robin grant.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : sub_share_arbiter_if.slave (request channels, tagged response)
// A request is taken in IDLE (or in RESP when the response is accepted),
// computed in CALC, and held in RESP until resp_ready.
module sub_share_arbiter
    import sub_share_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int NREQ = NREQ_DEF   // 2..RR_MAX
) (
    input  logic                  clk,
    input  logic                  rst,
    sub_share_arbiter_if.slave    bus
);

    localparam int ID_W = $clog2(NREQ);

    state_t          state, state_nxt;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] id_q;
    logic [N-1:0]    a_q, b_q;
    logic [N-1:0]    sum;
    logic            cout;

    rr_pick_t        pick;
    logic [ID_W-1:0] grant_id;
    logic            grant_en;
    logic [NREQ-1:0] ready;
    logic            take;

    logic            resp_valid_q, resp_borrow_q, resp_zero_q;
    logic [ID_W-1:0] resp_id_q;
    logic [N-1:0]    resp_diff_q;

    subtractor #(.N(N)) u_sub (
        .a    (a_q),
        .b    (b_q),
        .cin  (1'b1),
        .sum  (sum),
        .cout (cout)
    );

    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        pick     = rr_pick(RR_MAX'(bus.req_valid), RR_IDX_W'(rr_ptr));
        grant_id = ID_W'(pick.index);
        // Gating with rst keeps req_ready low while reset is asserted,
        // since the state register already reads IDLE during reset.
        grant_en = !rst && ((state == IDLE) ||
                            (state == RESP && bus.resp_ready));
        ready    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_en && pick.found && pick.index == RR_IDX_W'(i))
                ready[i] = 1'b1;
        end
        take      = |ready;
        state_nxt = state;
        case (state)
            IDLE:    if (take) state_nxt = CALC;
            CALC:    state_nxt = RESP;
            RESP:    if (bus.resp_ready) state_nxt = take ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            a_q           <= '0;
            b_q           <= '0;
            id_q          <= '0;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= '0;
            resp_diff_q   <= '0;
            resp_borrow_q <= 1'b0;
            resp_zero_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (take) begin
                a_q    <= bus.req_a[grant_id*N +: N];
                b_q    <= bus.req_b[grant_id*N +: N];
                id_q   <= grant_id;
                rr_ptr <= (grant_id == ID_W'(NREQ - 1)) ? '0
                                                         : grant_id + ID_W'(1);
            end
            if (state == CALC) begin
                resp_valid_q  <= 1'b1;
                resp_id_q     <= id_q;
                resp_diff_q   <= sum;
                resp_borrow_q <= ~cout;      // no carry out means a < b
                resp_zero_q   <= (sum == '0);
            end else if (state == RESP && bus.resp_ready) begin
                resp_valid_q  <= 1'b0;
            end
        end
    end

    assign bus.req_ready   = ready;
    assign bus.busy        = (state != IDLE);
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_id     = resp_id_q;
    assign bus.resp_diff   = resp_diff_q;
    assign bus.resp_borrow = resp_borrow_q;
    assign bus.resp_zero   = resp_zero_q;

endmodule

// File: tb/tb_sub_share_arbiter.sv
// Self-checking bench for sub_share_arbiter: a negedge monitor pushes the
// expected result of every request handshake into a queue and pops/compares
// it when the response is accepted; the stimulus process checks grants,
// latency, backpressure and reset behaviour.
module tb_sub_share_arbiter;

    localparam int N    = 3;
    localparam int NREQ = 4;

    typedef struct {
        int id;
        int diff;
        int borrow;
        int zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sub_share_arbiter_if #(.N(N), .NREQ(NREQ)) bus ();

    sub_share_arbiter #(.N(N), .NREQ(NREQ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t            exp_q[$];
    int              grant_log[$];
    int              grant_cyc[$];
    int              cyc = 0;
    logic [NREQ-1:0] hs_seen = '0;
    bit              auto_drop = 1'b1;
    int              errors = 0;
    int              checks = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input int id, input logic [N-1:0] a,
                                   input logic [N-1:0] b);
        exp_t         e;
        logic [N-1:0] d;
        d        = a - b;
        e.id     = id;
        e.diff   = int'(d);
        e.borrow = (a < b) ? 1 : 0;
        e.zero   = (d == '0) ? 1 : 0;
        return e;
    endfunction

    // Monitor / scoreboard.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        hs_seen = '0;
        if (rst) begin
            exp_q.delete();
        end else begin
            check("ready_onehot0", int'($onehot0(bus.req_ready)), 1);
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    hs_seen[i] = 1'b1;
                    exp_q.push_back(model(i, bus.req_a[i*N +: N], bus.req_b[i*N +: N]));
                    grant_log.push_back(i);
                    grant_cyc.push_back(cyc);
                end
            end
            if (bus.resp_valid && bus.resp_ready) begin
                if (exp_q.size() == 0) begin
                    check("resp_unexpected", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_id",     int'(bus.resp_id),     e.id);
                    check("resp_diff",   int'(bus.resp_diff),   e.diff);
                    check("resp_borrow", int'(bus.resp_borrow), e.borrow);
                    check("resp_zero",   int'(bus.resp_zero),   e.zero);
                end
            end
        end
    end

    // Advance to just after the next rising edge; granted requesters drop
    // their valid when auto_drop is set.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (auto_drop) bus.req_valid = bus.req_valid & ~hs_seen;
    endtask

    task automatic set_op(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
        bus.req_a[i*N +: N] = a;
        bus.req_b[i*N +: N] = b;
    endtask

    // Returns at the negedge of the handshake cycle of requester i.
    task automatic wait_hs(input int i, output int n);
        n = 0;
        @(negedge clk);
        while (!(bus.req_valid[i] && bus.req_ready[i]) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("grant_in_time", int'(n < 20), 1);
    endtask

    // One isolated operation with latency checks; ends in IDLE.
    task automatic do_op(input int i, input logic [N-1:0] a, input logic [N-1:0] b,
                         output int n);
        set_op(i, a, b);
        bus.req_valid[i] = 1'b1;
        wait_hs(i, n);
        check("grant_vector", int'(bus.req_ready), 1 << i);
        cycle();
        @(negedge clk);
        check("lat_t1_valid", int'(bus.resp_valid), 0);
        check("lat_t1_busy",  int'(bus.busy), 1);
        cycle();
        @(negedge clk);
        check("lat_t2_valid", int'(bus.resp_valid), 1);
        cycle();
    endtask

    initial begin
        int n;

        // Reset, with requests present to show req_ready stays low.
        rst            = 1'b1;
        bus.req_valid  = 4'b1111;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready",  int'(bus.req_ready), 0);
        check("rst_resp_valid", int'(bus.resp_valid), 0);
        check("rst_busy",       int'(bus.busy), 0);
        check("rst_resp_id",    int'(bus.resp_id), 0);
        check("rst_resp_diff",  int'(bus.resp_diff), 0);
        check("rst_resp_flags", int'({bus.resp_borrow, bus.resp_zero}), 0);
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        rst           = 1'b0;
        cycle();

        // First request granted in its own cycle; 5-1 = 4.
        do_op(0, 3'b101, 3'b001, n);
        check("t1_same_cycle_grant", n, 0);

        // Grant requester 3 so the pointer returns to 0.
        do_op(3, 3'd7, 3'd2, n);

        // All four held: grants 0,1,2,3,0 every 2 cycles.
        auto_drop = 1'b0;
        set_op(0, 3'd6, 3'd2);
        set_op(1, 3'd3, 3'd5);
        set_op(2, 3'd4, 3'd4);
        set_op(3, 3'd0, 3'd1);
        grant_log.delete();
        grant_cyc.delete();
        bus.req_valid = 4'b1111;
        n = 0;
        while (grant_log.size() < 5 && n < 40) begin
            cycle();
            n++;
        end
        bus.req_valid = '0;
        auto_drop     = 1'b1;
        check("rr_count", grant_log.size(), 5);
        for (int k = 0; k < grant_log.size(); k++)
            check($sformatf("rr_order_%0d", k), grant_log[k], k % NREQ);
        for (int k = 1; k < grant_cyc.size(); k++)
            check($sformatf("rr_spacing_%0d", k), grant_cyc[k] - grant_cyc[k-1], 2);
        repeat (4) cycle();

        // Requester 2 boundaries; leaves the pointer at 3.
        do_op(2, 3'b001, 3'b100, n);
        do_op(2, 3'b101, 3'b101, n);
        do_op(2, 3'b000, 3'b111, n);

        // Wrap: 1010 with pointer at 3 serves 3 then 1.
        set_op(1, 3'd2, 3'd1);
        set_op(3, 3'd6, 3'd3);
        grant_log.delete();
        bus.req_valid = 4'b1010;
        n = 0;
        while (grant_log.size() < 2 && n < 20) begin
            cycle();
            n++;
        end
        check("wrap_count", grant_log.size(), 2);
        if (grant_log.size() >= 2) begin
            check("wrap_first",  grant_log[0], 3);
            check("wrap_second", grant_log[1], 1);
        end
        repeat (4) cycle();

        // Backpressure: requester 0 result held 5 cycles while 1..3 wait.
        bus.resp_ready = 1'b0;
        set_op(0, 3'd6, 3'd1);
        bus.req_valid[0] = 1'b1;
        wait_hs(0, n);
        cycle();
        set_op(1, 3'd1, 3'd2);
        set_op(2, 3'd7, 3'd7);
        set_op(3, 3'd2, 3'd6);
        bus.req_valid = bus.req_valid | 4'b1110;
        n = 0;
        @(negedge clk);
        while (!bus.resp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("bp_resp_in_time", int'(n < 10), 1);
        for (int k = 0; k < 5; k++) begin
            check("bp_resp_valid", int'(bus.resp_valid), 1);
            check("bp_resp_id",    int'(bus.resp_id), 0);
            check("bp_resp_diff",  int'(bus.resp_diff), 5);
            check("bp_resp_flags", int'({bus.resp_borrow, bus.resp_zero}), 0);
            check("bp_req_ready",  int'(bus.req_ready), 0);
            check("bp_busy",       int'(bus.busy), 1);
            cycle();
            @(negedge clk);
        end
        cycle();
        bus.resp_ready = 1'b1;
        #1;
        check("bp_regrant_same_cycle", int'(bus.req_ready), 4'b0010);
        n = 0;
        while ((bus.req_valid != '0 || exp_q.size() != 0) && n < 40) begin
            cycle();
            n++;
        end
        check("bp_drained", int'(bus.req_valid), 0);
        repeat (2) cycle();

        // Asynchronous reset in CALC discards the operation.
        set_op(2, 3'd3, 3'd1);
        bus.req_valid[2] = 1'b1;
        wait_hs(2, n);
        cycle();
        bus.req_valid = 4'b0010;
        #1;
        check("pre_rst_busy", int'(bus.busy), 1);
        #1;
        rst = 1'b1;
        #1;
        check("arst_resp_valid", int'(bus.resp_valid), 0);
        check("arst_busy",       int'(bus.busy), 0);
        check("arst_req_ready",  int'(bus.req_ready), 0);
        repeat (2) cycle();
        bus.req_valid = '0;
        rst           = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post_rst_no_resp", int'(bus.resp_valid), 0);
        end
        cycle();
        set_op(1, 3'd4, 3'd1);
        set_op(3, 3'd1, 3'd1);
        bus.req_valid = 4'b1010;
        @(negedge clk);
        check("post_rst_ptr0_grant", int'(bus.req_ready), 4'b0010);
        n = 0;
        while ((bus.req_valid != '0 || exp_q.size() != 0) && n < 40) begin
            cycle();
            n++;
        end
        repeat (3) cycle();
        check("sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sub_share_arbiter.md
Name: sub_share_arbiter

Overview:
- Shares one N-bit `subtractor` instance between NREQ requesters.
- Round-robin grant, per-requester valid/ready request channel, one common response channel tagged with the requester id.
- Operands are registered and the result is registered, so the shared datapath sees stable inputs for a full cycle.
- Serves the CDC datapath wherever several clients need occasional a-b results (pointer distance, fill level) without one subtractor each.

Parameters:
- N, 3: operand/result width.
- NREQ, 4: number of requesters, ≥2.
- ID_W, $clog2(NREQ): derived width of resp_id; not overridable.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_a  in  NREQ*N  minuends, requester i at bits [i*N +: N].
- req_b  in  NREQ*N  subtrahends, same packing as req_a.
- req_ready  out  NREQ  one-hot-or-zero grant; operands are taken in the cycle where req_valid[i] and req_ready[i] are both 1.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_id  out  ID_W  index of the requester that owns the result.
- resp_diff  out  N  (a - b) mod 2^N.
- resp_borrow  out  1  1 when a < b (unsigned).
- resp_zero  out  1  1 when resp_diff == 0.
- busy  out  1  state != IDLE.

Behaviour:
- Reset is asynchronous, active-high: state=IDLE, rr_ptr=0, operand/id registers=0, resp_valid=0, resp_id=0, resp_diff=0, resp_borrow=0, resp_zero=0, busy=0, req_ready=0. An in-flight operation is discarded and no response is produced for it.
- FSM states: IDLE, CALC, RESP.
- Grant selection is combinational. It picks the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, … mod NREQ.
  - req_ready[g] is driven only in IDLE, or in RESP when resp_ready=1.
  - req_ready is never high for more than one requester.
- IDLE with any req_valid:
  - assert req_ready[g];
  - latch a_q/b_q/id_q from requester g;
  - set rr_ptr <= (g+1) mod NREQ;
  - go to CALC.
- IDLE with no req_valid: stay in IDLE.
- CALC:
  - drive subtractor a=a_q, b=b_q, cin=1, so sum = a + ~b + 1;
  - register resp_diff<=sum, resp_borrow<=~cout, resp_zero<=(sum==0), resp_id<=id_q;
  - set resp_valid<=1 and go to RESP.
  - req_ready=0 throughout CALC.
- RESP with resp_ready=0: hold every resp_* output stable; req_ready=0.
- RESP with resp_ready=1 and a pending request: perform the IDLE grant in the same cycle, clear resp_valid, go to CALC. This is back-to-back operation.
- RESP with resp_ready=1 and no request: clear resp_valid, go to IDLE.
- Timing:
  - Latency is request handshake in cycle T → resp_valid high in cycle T+2.
  - Sustained throughput is one result per 2 cycles while resp_ready=1.
- req_valid dropping while not granted: allowed. That requester is simply not served.
- Arithmetic is unsigned, mod 2^N, and borrow is not propagated between operations. Boundaries:
  - a=0, b=2^N-1 → diff=1, borrow=1.
  - a=b → diff=0, zero=1, borrow=0.
- Fairness: a requester held valid is granted within NREQ grants.

Decomposition:
- Package sub_share_pkg:
  - state enum {IDLE, CALC, RESP} (2 bits);
  - function rr_pick(valid, ptr) returning {found, index};
  - localparam defaults N_DEF=3, NREQ_DEF=4.
- One sub-module instance: `subtractor` #(.N(N)) with ports a, b, cin, sum, cout. cin is tied to 1. This is the shared resource.
- The FSM, grant logic and result registers stay in sub_share_arbiter.

Test Plan:
- Reset, then req_valid=0001 with a0=101, b0=001 at cycle T → req_ready=0001 at T; at T+2 resp_valid=1, id=0, diff=100, borrow=0, zero=0.
- Requester 2 with a=001, b=100 → diff=101, borrow=1. Then a=101, b=101 → diff=000, zero=1, borrow=0. Then a=000, b=111 → diff=001, borrow=1.
- All four req_valid held with distinct operands and resp_ready=1 → grants in order 0,1,2,3,0, one every 2 cycles. Each resp_id matches the operands sent by that requester.
- Wrap: drive rr_ptr to 3 via a grant to requester 2, then req_valid=1010 → grant 3 first, then 1.
- Backpressure: resp_ready=0 for 5 cycles while the others are valid → resp_* stable, req_ready=0, busy=1. When resp_ready is raised, a new grant occurs in that same cycle.
- Assert rst while in CALC (mid-cycle, asynchronous) → resp_valid, busy and req_ready go to 0 immediately. After release no response appears and the next grant starts from requester 0.
